mips32_alu_exec: RTL
====================

Name: mips32_alu_exec

Overview:
Execute-stage ALU datapath that consumes the 4-bit ALU_op and the 3-bit ALU_ctr unit-select produced by mips32_alu_ctrl, together with two 32-bit operands, and produces a registered result plus overflow and zero flags. Most operations complete in one cycle. CLZ/CLO runs iteratively under a small FSM. Upstream and downstream connect through valid/ready handshakes, so the block sits between decode/ctrl and the writeback register.

Parameters:
WIDTH, 32, operand/result width; fixed at 32 for MIPS32, and other values are unsupported.
CLZ_STEP, 4, bits scanned per cycle by the count-leading unit; WIDTH % CLZ_STEP must be 0.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  upstream presents an operation.
in_ready  output  1  block can accept an operation this cycle.
ALU_op  input  4  operation qualifier (signed/unsigned, sub, invert, byte/half).
ALU_ctr  input  3  functional-unit select from mips32_alu_ctrl.
A  input  WIDTH  operand A.
B  input  WIDTH  operand B.
out_valid  output  1  result/flags valid.
out_ready  input  1  downstream accepts result.
result  output  WIDTH  registered result.
overflow  output  1  signed overflow (add 0001, sub 1111 only).
zero  output  1  result == 0.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, out_valid=0, result=0, overflow=0, zero=0. An in-flight operation is discarded. in_ready rises on the first cycle after release.
- Handshake:
  - Accept occurs when in_valid & in_ready at a clock edge.
  - in_ready = (state==IDLE) | (state==DONE & out_ready).
  - Output transfer occurs when out_valid & out_ready. result, overflow and zero hold stable while out_valid & !out_ready.
- States:
  - IDLE: out_valid=0. On accept of a count op, go to BUSY. On accept of any other op, go to DONE.
  - BUSY: runs exactly N = WIDTH/CLZ_STEP cycles, then goes to DONE. in_ready=0.
  - DONE: out_valid=1. If out_ready & in_valid, accept the new op in the same cycle and go to DONE or BUSY accordingly. If out_ready & !in_valid, go to IDLE. If !out_ready, stay.
- Latency (accept at edge T):
  - Single-cycle ops: out_valid from edge T+1. Throughput is 1 op/cycle while out_ready=1.
  - Count ops: out_valid from edge T+N+1 (N=8 by default). Latency is fixed with no early exit.
- Unit select by ALU_ctr; ALU_op qualifies the operation:
  - 111 adder:
    - 0000 addu, 0001 add: A+B.
    - 1110 subu, 1111 sub: A-B.
    - overflow=1 only for 0001/1111 on signed overflow; otherwise 0. Result is always written (no trap suppression).
  - 000 count-leading:
    - 0010 clz.
    - 0011 clo: A is inverted before the scan.
    - The scan runs MSB-first, CLZ_STEP bits/cycle. The counter stops adding once the first 1 is seen.
    - Result range is 0..32; A=0 (clz) gives 32.
  - 100 AND: A&B (op 0100).
  - 101 OR/NOR: 0101 gives A|B; 0111 gives ~(A|B).
  - 010 XOR: A^B (op 0110).
  - 011 SEB: sign-extend A[7:0] (op 1000).
  - 001 SEH: sign-extend A[15:0] (op 1001).
  - 110 SLT: 1010 gives signed A<B; 1011 gives unsigned. Result is 0 or 1, zero-extended.
- zero is computed from the final result for every op. overflow is 0 for all non-adder ops.
- ALU_op 1100/1101 (unassigned) and any ALU_ctr/ALU_op combination not listed above: single-cycle, result=0, overflow=0, zero=1.
- Operands and op are captured at accept. Input changes after accept have no effect on the in-flight op.

Test Plan:
1. Reset mid-op: accept clz A=0x00F00000, assert rst_n=0 at cycle 3 of BUSY -> out_valid=0, result=0 immediately. After release, the IDLE accept of and A=0xF0F0F0F0 B=0xFF00FF00 gives result 0xF000F000 one cycle later.
2. Adder: ALU_op=0001 ctr=111 A=0x7FFFFFFF B=1 -> result 0x80000000, overflow=1. Same with op 0000 -> overflow=0. op 1111 A=0x80000000 B=1 -> 0x7FFFFFFF, overflow=1. op 1110 A=B=5 -> result 0, zero=1.
3. Count: op 0010 A=0x00F00000 -> result 8, out_valid exactly 9 cycles after accept. op 0010 A=0 -> 32. op 0011 A=0xFFFFFFFF -> 32. op 0011 A=0x7FFFFFFF -> 0.
4. Backpressure and throughput: hold out_ready=0 for 3 cycles after an xor -> result stable and in_ready=0. Then out_ready=1 with 4 back-to-back AND ops -> 4 results on 4 consecutive cycles.
5. Compare/extend: A=0xFFFFFFFF B=1: op 1010 -> 1, op 1011 -> 0. op 1000 A=0x00000080 -> 0xFFFFFF80. op 1001 A=0x00008000 -> 0xFFFF8000.
6. Illegal: op 1100 with ctr=111 -> result 0, overflow=0, zero=1, latency 1.

Source files
------------

// File: rtl/mips32_alu_exec.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mips32_alu_exec: execute-stage ALU with an iterative CLZ/CLO unit and   |
// | valid/ready handshakes on both sides.            Rev 1.0 - first issue  |
// +------------------------------------------------------------------------+
module mips32_alu_exec #(
  parameter int WIDTH    = 32,
  parameter int CLZ_STEP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALU_op,
  input  logic [2:0]       ALU_ctr,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             zero
);

  localparam int N_STEPS = WIDTH / CLZ_STEP;
  localparam int CNT_W   = $clog2(WIDTH + 1);
  localparam int STEP_W  = $clog2(N_STEPS + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic               init_q;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               overflow_q, overflow_d;
  logic               zero_q, zero_d;
  logic [WIDTH-1:0]   scan_q, scan_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               found_q, found_d;
  logic [STEP_W-1:0]  step_q, step_d;

  logic               accept;
  logic [WIDTH-1:0]   sum, diff;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf;
  logic               is_count;
  logic [CLZ_STEP-1:0] grp;
  logic [CNT_W-1:0]   grp_lz;
  logic               grp_hit;
  logic [CNT_W-1:0]   cnt_next;

  // init_q keeps in_ready low while in reset and rises on the first edge after release.
  assign in_ready  = init_q & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

  assign sum  = A + B;
  assign diff = A - B;

  always_comb begin
    alu_res  = '0;
    alu_ovf  = 1'b0;
    is_count = 1'b0;
    case (ALU_ctr)
      3'b111: begin
        if (ALU_op == 4'b0000 || ALU_op == 4'b0001) begin
          alu_res = sum;
          alu_ovf = (ALU_op == 4'b0001) & (A[WIDTH-1] == B[WIDTH-1]) &
                    (sum[WIDTH-1] != A[WIDTH-1]);
        end else if (ALU_op == 4'b1110 || ALU_op == 4'b1111) begin
          alu_res = diff;
          alu_ovf = (ALU_op == 4'b1111) & (A[WIDTH-1] != B[WIDTH-1]) &
                    (diff[WIDTH-1] != A[WIDTH-1]);
        end
      end
      3'b000: is_count = (ALU_op == 4'b0010) || (ALU_op == 4'b0011);
      3'b100: if (ALU_op == 4'b0100) alu_res = A & B;
      3'b101: begin
        if (ALU_op == 4'b0101)      alu_res = A | B;
        else if (ALU_op == 4'b0111) alu_res = ~(A | B);
      end
      3'b010: if (ALU_op == 4'b0110) alu_res = A ^ B;
      3'b011: if (ALU_op == 4'b1000) alu_res = {{(WIDTH-8){A[7]}}, A[7:0]};
      3'b001: if (ALU_op == 4'b1001) alu_res = {{(WIDTH-16){A[15]}}, A[15:0]};
      3'b110: begin
        if (ALU_op == 4'b1010)
          alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
        else if (ALU_op == 4'b1011)
          alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
      end
      default: ;
    endcase
  end

  // The scan register shifts left, so the group under test is always its top slice.
  assign grp = scan_q[WIDTH-1 -: CLZ_STEP];

  always_comb begin
    grp_lz  = CNT_W'(CLZ_STEP);
    grp_hit = 1'b0;
    for (int i = CLZ_STEP - 1; i >= 0; i--) begin
      if (!grp_hit && grp[i]) begin
        grp_lz  = CNT_W'(CLZ_STEP - 1 - i);
        grp_hit = 1'b1;
      end
    end
  end

  assign cnt_next = found_q ? cnt_q : (cnt_q + grp_lz);

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
    scan_d     = scan_q;
    cnt_d      = cnt_q;
    found_d    = found_q;
    step_d     = step_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          if (is_count) begin
            state_d = BUSY;
            scan_d  = ALU_op[0] ? ~A : A;
            cnt_d   = '0;
            found_d = 1'b0;
            step_d  = '0;
          end else begin
            state_d    = DONE;
            result_d   = alu_res;
            overflow_d = alu_ovf;
            zero_d     = (alu_res == '0);
          end
        end else if (state_q == DONE && out_ready) begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        scan_d  = scan_q << CLZ_STEP;
        cnt_d   = cnt_next;
        found_d = found_q | grp_hit;
        step_d  = step_q + 1'b1;
        if (step_q == STEP_W'(N_STEPS - 1)) begin
          state_d    = DONE;
          result_d   = WIDTH'(cnt_next);
          overflow_d = 1'b0;
          zero_d     = (cnt_next == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q     <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      scan_q     <= '0;
      cnt_q      <= '0;
      found_q    <= 1'b0;
      step_q     <= '0;
    end else begin
      init_q     <= 1'b1;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
      scan_q     <= scan_d;
      cnt_q      <= cnt_d;
      found_q    <= found_d;
      step_q     <= step_d;
    end
  end

endmodule
`default_nettype wire
